// File: rtl/sub_bytes_serial.sv
// Serial AES SubBytes: one state byte per cycle through an external S-box.
// 16 cycles from accept to out_valid; the result is held in DONE until out_ready.
module sub_bytes_serial (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic [7:0]   sbox_addr,
  input  logic [7:0]   sbox_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [15:0][7:0]  blk_q, blk_d;
  logic [3:0]        slot;

  // Byte 0 lives in the most significant lane, so lane = 15 - index.
  assign slot = 4'd15 - idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    blk_d     = blk_q;
    in_ready  = 1'b0;
    sbox_addr = 8'h00;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          blk_d   = in_state;
          idx_d   = 4'd0;
          state_d = SUB;
        end
      end
      SUB: begin
        busy        = 1'b1;
        sbox_addr   = blk_q[slot];
        blk_d[slot] = sbox_data;
        // Index wraps 15 -> 0 on the final byte, leaving it ready for the next block.
        idx_d       = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_state = blk_q;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Bench for sub_bytes_serial: behavioural S-box on the sbox port, SubBytes
// reference model, directed scenarios plus randomized blocks and stalls.
module tb_sub_bytes_serial;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [7:0]   sbox_addr;
  logic [7:0]   sbox_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sbox_data = SBOX[sbox_addr];

  always #5 clk = ~clk;

  sub_bytes_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .sbox_addr (sbox_addr),
    .sbox_data (sbox_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  function automatic logic [127:0] ref_sub(input logic [127:0] x);
    logic [127:0] v;
    logic [127:0] r;
    v = x;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r = {r[119:0], SBOX[v[127:120]]};
      v = {v[119:0], 8'h00};
    end
    return r;
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] x, input int i);
    logic [127:0] t;
    t = x >> (8 * (15 - i));
    return t[7:0];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    check("in_ready_wait", 128'(in_ready), 128'd1);
  endtask

  // One full block: accept, 16 SUB cycles, optional DONE stall, handshake.
  task automatic run_block(input logic [127:0] din, input logic [127:0] exp, input int hold);
    wait_ready();
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_state  = din;
    step();
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_state = rnd128();
      check("sub_busy", 128'(busy), 128'd1);
      check("sub_in_ready", 128'(in_ready), 128'd0);
      check("sub_out_valid", 128'(out_valid), 128'd0);
      check("sbox_addr", 128'(sbox_addr), 128'(byte_of(din, k)));
      step();
    end
    for (int h = 0; h < hold; h++) begin
      check("stall_valid", 128'(out_valid), 128'd1);
      check("stall_state", out_state, exp);
      check("stall_in_ready", 128'(in_ready), 128'd0);
      check("stall_busy", 128'(busy), 128'd0);
      in_valid = 1'b1;
      in_state = rnd128();
      step();
    end
    check("done_valid", 128'(out_valid), 128'd1);
    check("done_state", out_state, exp);
    check("done_busy", 128'(busy), 128'd0);
    check("done_sbox_addr", 128'(sbox_addr), 128'd0);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    check("post_hs_valid", 128'(out_valid), 128'd0);
    check("post_hs_in_ready", 128'(in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] din;
    logic [127:0] q[$];
    logic         seen;
    logic         acc;
    int           last;
    int           cyc;
    int           accepts;
    int           outs;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_sbox_addr", 128'(sbox_addr), 128'd0);
    check("rst_out_state", out_state, 128'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("rel_in_ready", 128'(in_ready), 128'd1);

    run_block(128'h00112233445566778899aabbccddeeff,
              128'h638293c31bfc33f5c4eeacea4bc12816, 0);
    run_block(128'h0, {16{8'h63}}, 0);
    din = rnd128();
    run_block(din, ref_sub(din), 5);

    // Reset in the middle of SUB, with index at 7.
    wait_ready();
    out_ready = 1'b1;
    din       = rnd128();
    in_valid  = 1'b1;
    in_state  = din;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) step();
    check("mid_sbox_addr7", 128'(sbox_addr), 128'(byte_of(din, 7)));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready), 128'd0);
    check("mid_rst_state", out_state, 128'd0);
    check("mid_rst_sbox_addr", 128'(sbox_addr), 128'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready", 128'(in_ready), 128'd1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      seen = seen | out_valid;
      step();
    end
    check("mid_no_out_valid", 128'(seen), 128'd0);
    run_block({128{1'b1}}, {16{8'h16}}, 0);

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = rnd128();
    last      = -1;
    cyc       = 0;
    accepts   = 0;
    outs      = 0;
    while (outs < 6 && cyc < 300) begin
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (q.size() > 0) check("b2b_data", out_state, q.pop_front());
        else check("b2b_extra_out", 128'(out_valid), 128'd0);
        outs++;
      end
      if (acc) begin
        q.push_back(ref_sub(in_state));
        if (last >= 0) check("b2b_interval", 128'(cyc - last), 128'd18);
        last = cyc;
        accepts++;
      end
      step();
      cyc++;
      if (acc) begin
        in_state = rnd128();
        if (accepts == 6) in_valid = 1'b0;
      end
    end
    check("b2b_outputs", 128'(outs), 128'd6);
    check("b2b_accepts", 128'(accepts), 128'd6);
    check("b2b_queue_empty", 128'(q.size()), 128'd0);

    for (int n = 0; n < 8; n++) begin
      din = rnd128();
      run_block(din, ref_sub(din), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
